// File: rtl/line_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// line_xfer_ctrl
// Moves one 4-word cache line (4 x 16 bit) between the cache controller and
// four single-word memory banks. Word k of a line always lives in bank k.
// A fill (mem_rd) issues four bank reads and assembles the returned words
// into rd_line. An evict (mem_wr) issues four bank writes from wr_line.
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   mem_rd      in   line-fill request (only honoured in IDLE)
//   mem_wr      in   line-evict request (only honoured in IDLE)
//   line_addr   in   13-bit line address
//   wr_line     in   64-bit evict data, captured when the request is taken
//   bank_rd_en  out  single-word bank read strobe
//   bank_wr_en  out  single-word bank write strobe
//   bank_addr   out  16-bit word address {line_addr, word, 1'b0}
//   bank_wdata  out  16-bit write data
//   bank_rdata  in   bank read data, valid 2 cycles after its read strobe
//   rd_line     out  assembled fill line
//   busy        out  per-bank busy vector (4 cycles from each access)
//   done        out  one-cycle completion pulse
//   err         out  one-cycle protocol-error pulse
// ---------------------------------------------------------------------------
module line_xfer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [12:0] line_addr,
  input  logic [63:0] wr_line,
  output logic        bank_rd_en,
  output logic        bank_wr_en,
  output logic [15:0] bank_addr,
  output logic [15:0] bank_wdata,
  input  logic [15:0] bank_rdata,
  output logic [63:0] rd_line,
  output logic [3:0]  busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FSM / transfer context
  state_t      r_state;
  logic [1:0]  r_cnt;        // word currently on the bank bus while in ISSUE
  logic        r_drain;      // second DRAIN cycle marker
  logic        r_op_rd;
  logic [12:0] r_line_addr;
  logic [63:0] r_wline;
  logic        r_done;
  logic        r_err;

  // registered bank interface
  logic        r_bank_rd_en;
  logic        r_bank_wr_en;
  logic [15:0] r_bank_addr;
  logic [15:0] r_bank_wdata;
  logic [63:0] r_rd_line;
  logic [3:0]  r_busy;
  logic [1:0]  r_busy_cnt [4];

  // read-return alignment pipeline (bank data lags the strobe by 2 cycles)
  logic        r_p1_vld;
  logic [1:0]  r_p1_idx;
  logic        r_p2_vld;
  logic [1:0]  r_p2_idx;

  // next-access decode
  logic        w_accept;
  logic        w_bad_req;
  logic        w_issue;
  logic        w_issue_rd;
  logic [1:0]  w_issue_idx;
  logic [12:0] w_issue_laddr;
  logic [63:0] w_issue_wline;
  logic [15:0] w_issue_word;

  // Decide which word (if any) goes out on the bank bus next cycle.
  // On acceptance the first word is taken straight from the inputs so that
  // word 0 appears in the very next cycle.
  always_comb begin
    w_accept      = 1'b0;
    w_bad_req     = 1'b0;
    w_issue       = 1'b0;
    w_issue_rd    = 1'b0;
    w_issue_idx   = 2'd0;
    w_issue_laddr = 13'd0;
    w_issue_wline = 64'd0;
    if (r_state == S_IDLE) begin
      w_accept  = mem_rd ^ mem_wr;
      w_bad_req = mem_rd & mem_wr;
    end else begin
      w_bad_req = mem_rd | mem_wr;
    end
    if (w_accept) begin
      w_issue       = 1'b1;
      w_issue_rd    = mem_rd;
      w_issue_idx   = 2'd0;
      w_issue_laddr = line_addr;
      w_issue_wline = wr_line;
    end else if ((r_state == S_ISSUE) && (r_cnt != 2'd3)) begin
      w_issue       = 1'b1;
      w_issue_rd    = r_op_rd;
      w_issue_idx   = r_cnt + 2'd1;
      w_issue_laddr = r_line_addr;
      w_issue_wline = r_wline;
    end else begin
      w_issue       = 1'b0;
    end
    w_issue_word = w_issue_wline[{w_issue_idx, 4'b0000} +: 16];
  end

  // Transfer FSM: sequencing, request latching, done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_drain     <= 1'b0;
      r_op_rd     <= 1'b0;
      r_line_addr <= 13'd0;
      r_wline     <= 64'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_bad_req;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_ISSUE;
            r_cnt       <= 2'd0;
            r_op_rd     <= mem_rd;
            r_line_addr <= line_addr;
            r_wline     <= wr_line;
          end
        end
        S_ISSUE: begin
          if (r_cnt == 2'd3) begin
            r_cnt <= 2'd0;
            if (r_op_rd) begin
              r_state <= S_DRAIN;
              r_drain <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DRAIN: begin
          // two cycles waiting for the last read word to come back
          if (r_drain) begin
            r_drain <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bank bus registers, busy counters and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_rd_en <= 1'b0;
      r_bank_wr_en <= 1'b0;
      r_bank_addr  <= 16'd0;
      r_bank_wdata <= 16'd0;
      r_rd_line    <= 64'd0;
      r_busy       <= 4'd0;
      r_p1_vld     <= 1'b0;
      r_p1_idx     <= 2'd0;
      r_p2_vld     <= 1'b0;
      r_p2_idx     <= 2'd0;
      for (int b = 0; b < 4; b++) begin
        r_busy_cnt[b] <= 2'd0;
      end
    end else begin
      r_bank_rd_en <= w_issue & w_issue_rd;
      r_bank_wr_en <= w_issue & ~w_issue_rd;
      r_bank_addr  <= w_issue ? {w_issue_laddr, w_issue_idx, 1'b0} : 16'd0;
      r_bank_wdata <= (w_issue && !w_issue_rd) ? w_issue_word : 16'd0;

      // busy flag covers the access cycle plus three more: counter runs
      // 3,2,1,0 while the flag is held, the flag drops after reaching 0
      for (int b = 0; b < 4; b++) begin
        if (w_issue && (w_issue_idx == 2'(b))) begin
          r_busy[b]     <= 1'b1;
          r_busy_cnt[b] <= 2'd3;
        end else if (r_busy_cnt[b] != 2'd0) begin
          r_busy_cnt[b] <= r_busy_cnt[b] - 2'd1;
        end else begin
          r_busy[b] <= 1'b0;
        end
      end

      // word index rides along with the strobe so returning data lands in
      // the right slice of rd_line
      r_p1_vld <= r_bank_rd_en;
      r_p1_idx <= r_bank_addr[2:1];
      r_p2_vld <= r_p1_vld;
      r_p2_idx <= r_p1_idx;
      if (r_p2_vld) begin
        r_rd_line[{r_p2_idx, 4'b0000} +: 16] <= bank_rdata;
      end
    end
  end

  assign bank_rd_en = r_bank_rd_en;
  assign bank_wr_en = r_bank_wr_en;
  assign bank_addr  = r_bank_addr;
  assign bank_wdata = r_bank_wdata;
  assign rd_line    = r_rd_line;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
